fixed_point_alu: RTL and testbench

Parametrised, handshaked successor to the single-width fixed-point unit. Performs signed two's-complement Q-format add, subtract, multiply and square root with selectable saturation. It uses an explicit start/ready/valid protocol, so the execute stage launches an operation once and waits for a one-cycle completion pulse. Multiply is computed sequentially from four half-width partial products; square root uses a restoring digit-by-digit core.

---
 rtl/fixed_point_alu_pkg.sv | 14 +
 rtl/fxp_sqrt_core.sv | 72 +++++++
 rtl/fixed_point_alu.sv | 192 +++++++++++++++++++
 tb/tb_fixed_point_alu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_alu_pkg.sv
// Shared opcode encoding and constants for the fixed-point ALU and its execute-stage users.
package fixed_point_alu_pkg;

  typedef enum logic [1:0] {
    FPU_ADD  = 2'd0,
    FPU_SUB  = 2'd1,
    FPU_MUL  = 2'd2,
    FPU_SQRT = 2'd3
  } fpu_op_e;

  // Index of the final (hi*hi) partial product of the sequential multiply.
  localparam int PP_LAST = 3;

endpackage

// File: rtl/fxp_sqrt_core.sv
// Restoring digit-by-digit square root: one result bit per cycle after a one-cycle load on go.
module fxp_sqrt_core
  import fixed_point_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [WIDTH+FBITS-1:0]   radicand,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         root
);

  localparam int RW   = WIDTH + FBITS;
  localparam int ITER = RW / 2;
  localparam int AW   = ITER + 1;
  localparam int CW   = $clog2(ITER + 1);

  logic [RW-1:0]   x_q, x_d;
  logic [AW-1:0]   ac_q, ac_d;
  logic [ITER-1:0] q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [AW+1:0] acShift;
  logic [AW+1:0] trialDivisor;
  logic          fits;

  // Remainder stays below 2^AW throughout, so the truncating casts below never drop live bits.
  assign acShift      = {ac_q, x_q[RW-1:RW-2]};
  assign trialDivisor = {1'b0, q_q, 2'b01};
  assign fits         = (acShift >= trialDivisor);

  assign busy = (cnt_q != '0);
  assign done = busy && (cnt_q == CW'(1));
  assign root = {{(WIDTH-ITER){1'b0}}, q_d};

  always_comb begin
    x_d   = x_q;
    ac_d  = ac_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    if (go) begin
      x_d   = radicand;
      ac_d  = '0;
      q_d   = '0;
      cnt_d = CW'(ITER);
    end else if (busy) begin
      x_d   = {x_q[RW-3:0], 2'b00};
      ac_d  = fits ? AW'(acShift - trialDivisor) : AW'(acShift);
      q_d   = {q_q[ITER-2:0], fits};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q   <= '0;
      ac_q  <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      x_q   <= x_d;
      ac_q  <= ac_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fixed_point_alu.sv
// Handshaked signed Q-format ALU: single-cycle add/sub, four-step sequential multiply, iterative sqrt.
module fixed_point_alu
  import fixed_point_alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FBITS    = 10,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0]   MAX_POS     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MIN_NEG     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] MAG_POS_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MAG_NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, SQRT, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     opA_q, opA_d, opB_q, opB_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [1:0]           ppIdx_q, ppIdx_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 overflow_q, overflow_d;

  logic                 accept;
  logic [WIDTH:0]       sumWide;
  logic                 addOvf;
  logic [WIDTH-1:0]     magA, magB;
  logic [HALF-1:0]      mulX, mulY;
  logic [WIDTH-1:0]     pp;
  logic [2*WIDTH-1:0]   ppShifted, accSum, mulMag;
  logic                 mulNeg, mulOvf;
  logic [WIDTH-1:0]     mulWrap;
  logic                 sqrtGo, sqrtBusy, sqrtDone;
  logic [WIDTH-1:0]     sqrtRoot;

  function automatic logic [WIDTH-1:0] limitResult(input logic ovf, input logic negative,
                                                   input logic [WIDTH-1:0] wrapped);
    if (ovf && SATURATE) return negative ? MIN_NEG : MAX_POS;
    return wrapped;
  endfunction

  assign ready    = (state_q == IDLE) || (state_q == DONE);
  assign valid    = (state_q == DONE);
  assign result   = result_q;
  assign overflow = overflow_q;
  assign accept   = start && ready;

  // The extra top bit holds the true sign, so overflow is a disagreement with bit WIDTH-1.
  assign sumWide = (fpu_op_e'(operation) == FPU_SUB)
                 ? {operand_1[WIDTH-1], operand_1} - {operand_2[WIDTH-1], operand_2}
                 : {operand_1[WIDTH-1], operand_1} + {operand_2[WIDTH-1], operand_2};
  assign addOvf  = sumWide[WIDTH] ^ sumWide[WIDTH-1];

  assign magA   = opA_q[WIDTH-1] ? -opA_q : opA_q;
  assign magB   = opB_q[WIDTH-1] ? -opB_q : opB_q;
  assign mulNeg = opA_q[WIDTH-1] ^ opB_q[WIDTH-1];

  always_comb begin
    mulX      = magA[HALF-1:0];
    mulY      = magB[HALF-1:0];
    ppShifted = {{WIDTH{1'b0}}, pp};
    case (ppIdx_q)
      2'd1: begin
        mulX      = magA[WIDTH-1:HALF];
        ppShifted = {{HALF{1'b0}}, pp, {HALF{1'b0}}};
      end
      2'd2: begin
        mulY      = magB[WIDTH-1:HALF];
        ppShifted = {{HALF{1'b0}}, pp, {HALF{1'b0}}};
      end
      2'd3: begin
        mulX      = magA[WIDTH-1:HALF];
        mulY      = magB[WIDTH-1:HALF];
        ppShifted = {pp, {WIDTH{1'b0}}};
      end
      default: ;
    endcase
  end

  assign pp     = {{HALF{1'b0}}, mulX} * {{HALF{1'b0}}, mulY};
  assign accSum = acc_q + ppShifted;
  assign mulMag = accSum >> FBITS;
  // A negative product may reach exactly 2^(WIDTH-1) and still be representable.
  assign mulOvf  = mulNeg ? (mulMag > MAG_NEG_MAX) : (mulMag > MAG_POS_MAX);
  assign mulWrap = mulNeg ? -mulMag[WIDTH-1:0] : mulMag[WIDTH-1:0];

  assign sqrtGo = accept && (fpu_op_e'(operation) == FPU_SQRT) && !operand_1[WIDTH-1];

  fxp_sqrt_core #(
    .WIDTH (WIDTH),
    .FBITS (FBITS)
  ) u_sqrt (
    .clk      (clk),
    .reset    (reset),
    .go       (sqrtGo),
    .radicand ({operand_1, {FBITS{1'b0}}}),
    .busy     (sqrtBusy),
    .done     (sqrtDone),
    .root     (sqrtRoot)
  );

  // Next-state logic; an accepted start overrides the DONE->IDLE return for back-to-back issue.
  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    acc_d      = acc_q;
    ppIdx_d    = ppIdx_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    case (state_q)
      MUL: begin
        acc_d   = accSum;
        ppIdx_d = ppIdx_q + 2'd1;
        if (ppIdx_q == 2'(PP_LAST)) begin
          result_d   = limitResult(mulOvf, mulNeg, mulWrap);
          overflow_d = mulOvf;
          state_d    = DONE;
        end
      end
      SQRT: begin
        if (sqrtBusy && sqrtDone) begin
          result_d   = sqrtRoot;
          overflow_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    if (accept) begin
      opA_d = operand_1;
      opB_d = operand_2;
      case (fpu_op_e'(operation))
        FPU_ADD, FPU_SUB: begin
          result_d   = limitResult(addOvf, sumWide[WIDTH], sumWide[WIDTH-1:0]);
          overflow_d = addOvf;
          state_d    = DONE;
        end
        FPU_MUL: begin
          acc_d   = '0;
          ppIdx_d = 2'd0;
          state_d = MUL;
        end
        FPU_SQRT: begin
          if (operand_1[WIDTH-1]) begin
            result_d   = '0;
            overflow_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = SQRT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      acc_q      <= '0;
      ppIdx_q    <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      acc_q      <= acc_d;
      ppIdx_q    <= ppIdx_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_fixed_point_alu.sv
// Scoreboard bench: saturating and wrapping instances share stimulus; a negedge monitor checks each.
module tb_fixed_point_alu;
  import fixed_point_alu_pkg::*;

  localparam int W = 32;
  localparam int F = 10;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           acc;
    int           vcyc;
  } expT;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   operation = 2'd0;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic         ready0, valid0, overflow0, ready1, valid1, overflow1;
  logic [W-1:0] result0, result1;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  readyAt = 0;
  expT sbQ0[$];
  expT sbQ1[$];
  logic [W-1:0] heldRes [2];
  logic         heldOvf [2];

  fixed_point_alu #(.WIDTH(W), .FBITS(F), .SATURATE(1'b1)) dutSat (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .operand_1(operand1), .operand_2(operand2),
    .ready(ready0), .valid(valid0), .result(result0), .overflow(overflow0));

  fixed_point_alu #(.WIDTH(W), .FBITS(F), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .operand_1(operand1), .operand_2(operand2),
    .ready(ready1), .valid(valid1), .result(result1), .overflow(overflow1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint isqrt(input longint n);
    longint x;
    x = longint'($sqrt(real'(n)));
    while (x * x > n) x--;
    while ((x + 1) * (x + 1) <= n) x++;
    return x;
  endfunction

  // Reference model: plain integer arithmetic on the Q values, latency in cycles from accept.
  function automatic void modelOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit sat, output logic [W-1:0] r, output logic o, output int lat);
    longint       s, root;
    logic [W-1:0] absA, absB, wr;
    logic [63:0]  mag, lim;
    bit           neg;
    r = '0; o = 1'b0; lat = 1;
    case (op)
      2'd0, 2'd1: begin
        s = (op == 2'd0) ? longint'($signed(a)) + longint'($signed(b))
                         : longint'($signed(a)) - longint'($signed(b));
        r = s[31:0];
        if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
          o = 1'b1;
          if (sat) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
      end
      2'd2: begin
        absA = a[31] ? (~a + 32'd1) : a;
        absB = b[31] ? (~b + 32'd1) : b;
        mag  = ({32'd0, absA} * {32'd0, absB}) >> F;
        neg  = a[31] ^ b[31];
        lim  = neg ? 64'd2147483648 : 64'd2147483647;
        o    = (mag > lim);
        wr   = neg ? (32'd0 - mag[31:0]) : mag[31:0];
        r    = (o && sat) ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : wr;
        lat  = 5;
      end
      default: begin
        if (a[31]) begin
          o = 1'b1;
        end else begin
          root = isqrt(longint'(a) * 1024);
          r    = root[31:0];
          lat  = (W + F) / 2 + 1;
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] randOperand();
    logic [W-1:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0: return v;
      1: return W'($signed(v) >>> $urandom_range(8, 28));
      2: return W'($signed(v) >>> $urandom_range(18, 30));
      default: begin
        case ($urandom_range(0, 3))
          0: return 32'h7FFF_FFFF;
          1: return 32'h8000_0000;
          2: return 32'h0000_0000;
          default: return 32'hFFFF_FFFF;
        endcase
      end
    endcase
  endfunction

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      start     = 1'b0;
      operation = 2'($urandom);
      operand1  = $urandom;
      operand2  = $urandom;
      @(posedge clk); #1;
    end
  endtask

  // Drives start for one cycle; the expectation is queued only if the model says it will be accepted.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit waitReady);
    expT e0, e1;
    int  lat;
    if (waitReady) while (cyc + 1 < readyAt) idleCycles(1);
    start = 1'b1; operation = op; operand1 = a; operand2 = b;
    if (cyc + 1 >= readyAt) begin
      modelOp(op, a, b, 1'b1, e0.res, e0.ovf, lat);
      modelOp(op, a, b, 1'b0, e1.res, e1.ovf, lat);
      e0.acc = cyc + 1; e0.vcyc = cyc + lat;
      e1.acc = cyc + 1; e1.vcyc = cyc + lat;
      sbQ0.push_back(e0);
      sbQ1.push_back(e1);
      readyAt = cyc + 1 + lat;
    end
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    start = 1'b0;
    sbQ0.delete();
    sbQ1.delete();
    readyAt = 0;
    heldRes[0] = '0; heldRes[1] = '0;
    heldOvf[0] = 1'b0; heldOvf[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic checkOutput(input int d, input logic rdy, input logic v, input logic [W-1:0] r,
                             input logic o);
    expT  e;
    bit   have;
    logic expRdy;
    have = 1'b0;
    if (d == 0 && sbQ0.size() > 0) begin have = 1'b1; e = sbQ0[0]; end
    if (d == 1 && sbQ1.size() > 0) begin have = 1'b1; e = sbQ1[0]; end
    if (reset) begin
      checks++;
      if (rdy !== 1'b1 || v !== 1'b0 || r !== '0 || o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL resetOutputs dut%0d cyc %0d: ready=%b valid=%b result=%h overflow=%b, expected 1 0 00000000 0",
                 d, cyc, rdy, v, r, o);
      end
    end else begin
      expRdy = !(have && e.acc <= cyc && cyc < e.vcyc);
      checks++;
      if (rdy !== expRdy) begin
        errors++;
        $display("[TB] FAIL ready dut%0d cyc %0d: got %b expected %b", d, cyc, rdy, expRdy);
      end
      checks++;
      if (have && e.vcyc == cyc) begin
        if (v !== 1'b1 || r !== e.res || o !== e.ovf) begin
          errors++;
          $display("[TB] FAIL result dut%0d cyc %0d: valid=%b result=%h overflow=%b, expected 1 %h %b",
                   d, cyc, v, r, o, e.res, e.ovf);
        end
        if (d == 0) void'(sbQ0.pop_front());
        else        void'(sbQ1.pop_front());
        heldRes[d] = e.res;
        heldOvf[d] = e.ovf;
      end else if (v !== 1'b0 || r !== heldRes[d] || o !== heldOvf[d]) begin
        errors++;
        $display("[TB] FAIL heldOutputs dut%0d cyc %0d: valid=%b result=%h overflow=%b, expected 0 %h %b",
                 d, cyc, v, r, o, heldRes[d], heldOvf[d]);
      end
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0, ready0, valid0, result0, overflow0);
    checkOutput(1, ready1, valid1, result1, overflow1);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    heldRes[0] = '0; heldRes[1] = '0;
    heldOvf[0] = 1'b0; heldOvf[1] = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(FPU_ADD, 32'h0000_0C00, 32'h0000_0400, 1'b1);
    idleCycles(2);
    applyStimulus(FPU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    applyStimulus(FPU_SUB, 32'h8000_0000, 32'h0000_0001, 1'b1);
    idleCycles(1);
    applyStimulus(FPU_MUL, 32'h0000_0A00, 32'hFFFF_FA00, 1'b1);
    idleCycles(6);
    applyStimulus(FPU_MUL, 32'h4000_0000, 32'h0000_0800, 1'b1);
    applyStimulus(FPU_MUL, 32'h8000_0000, 32'h0000_0400, 1'b1);
    applyStimulus(FPU_SQRT, 32'h0000_0800, 32'h0, 1'b1);
    applyStimulus(FPU_SQRT, 32'hFFFF_FC00, 32'h0, 1'b1);
    idleCycles(2);

    for (int k = 1; k <= 3; k++) applyStimulus(FPU_ADD, 32'h0000_0001, W'(k), 1'b1);
    idleCycles(2);

    // Sqrt in flight, ignored start pulses while busy, then reset aborts it.
    applyStimulus(FPU_SQRT, 32'h0012_3456, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(FPU_ADD, $urandom, $urandom, 1'b0);
    idleCycles(6);
    doReset();
    applyStimulus(FPU_ADD, 32'h0000_1234, 32'hFFFF_F000, 1'b1);
    idleCycles(2);

    for (int n = 0; n < 200; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), randOperand(), randOperand(), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end
    idleCycles(30);

    checks++;
    if (sbQ0.size() != 0 || sbQ1.size() != 0) begin
      errors++;
      $display("[TB] FAIL pendingResults: got %0d/%0d outstanding expected 0/0", sbQ0.size(), sbQ1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
